rank_filter: RTL and testbench
==============================

Name: rank_filter

Overview:
- Parametrised successor to the fixed 9-tap median block.
- Collects a window of P unsigned W-bit samples from a serial valid-qualified stream.
- Sorts the window in place with an odd-even transposition network, one pass per clock.
- Emits the sample at a runtime-selectable rank (min, median, max or any rank) with a one-cycle strobe. Sits in the video pixel path between the capture stream and downstream processing.

Parameters:
- W, 8, sample width in bits (unsigned).
- P, 9, window depth; odd, 3..25.
- RW, $clog2(P), rank/count index width (derived; not overridden).

Ports:
- CLK  in  1  clock; all logic on posedge.
- nRST  in  1  reset, synchronous and active-low; sampled on posedge CLK.
- DI  in  W  input sample.
- DSI  in  1  DI valid; one sample accepted per cycle when high and not BUSY.
- RANK  in  RW  output rank; 0 = minimum, (P-1)/2 = median, P-1 = maximum.
- DO  out  W  selected-rank result; registered; holds until the next result.
- DSO  out  1  result strobe; high exactly one cycle per window.
- BUSY  out  1  high while sorting; DSI ignored while high.

Behaviour:
- Reset (nRST low at posedge):
  - state <= LOAD, sample count <= 0, pass count <= 0.
  - DO <= 0, DSO <= 0, BUSY <= 0.
  - Array contents are don't-care.
  - Reset mid-LOAD or mid-SORT discards the partial window; no DSO follows.
- States: LOAD, SORT.
- LOAD:
  - BUSY = 0.
  - On DSI=1: arr[0] <= DI, arr[i] <= arr[i-1], count++.
  - DSI may gap; count holds while DSI=0.
  - RANK is latched with the first sample of a window (count==0).
  - A latched RANK >= P is clamped to P-1.
  - The sample that makes count reach P moves to SORT on the same edge and clears count.
- SORT:
  - BUSY = 1; DSI and DI are ignored.
  - Pass p (0..P-1): p even compares pairs (0,1),(2,3)...; p odd compares pairs (1,2),(3,4)...
  - Each pair is swapped so that arr[lower] <= arr[upper] (unsigned compare). Equal values are not swapped.
  - On the edge of pass P-1: DO <= pass_output[latched RANK], DSO <= 1, state <= LOAD.
- Latency: the last sample is captured at edge k; passes run at edges k+1..k+P; DSO is high in the cycle after edge k+P.
- DSO is cleared on the next edge.
- Back-to-back windows: the cycle with DSO=1 is a LOAD cycle and may accept sample 1 of the next window.
- Throughput: one result per P accepted samples plus P sort cycles.
- DO changes only on a DSO-producing edge or on reset.

Optional Feature:
- Macro: RANK_FILTER_EARLY_EXIT_EN.
- Defined:
  - A swap flag per pass is recorded.
  - SORT ends after any pass p >= 1 where neither pass p nor pass p-1 swapped. Minimum 2 passes.
  - DO/DSO are produced on that edge, exactly as for pass P-1.
  - Latency varies, 2..P.
  - Already-sorted input gives DSO in the cycle after edge k+2.
- Undefined: exactly P passes always; no swap-flag logic synthesised.

Decomposition:
- Package rank_filter_pkg:
  - state enum {LOAD, SORT} (logic [0:0]).
  - RANK_MIN = 0.
  - function median_rank(P) returning (P-1)/2.
  - parameter legality check (P odd, 3..25) used by an elaboration-time assertion.
- Sub-module rank_filter_oe_pass:
  - Combinational, parameters W and P.
  - Inputs: packed array and a parity bit.
  - Outputs: next array and an any_swap flag.
  - Top instantiates one and registers its output each SORT cycle.

Test Plan:
- W=8, P=9, RANK=4; DSI contiguous with 9,3,7,1,5,8,2,6,4 -> DSO one cycle, 9 cycles after the last sample edge; DO=5; BUSY high for 9 cycles.
- Same window, RANK=0 then RANK=8 on separate windows -> DO=1 and DO=9. RANK=12 -> clamped, DO=9.
- Same window with DSI low for 3 cycles between samples 4 and 5 -> identical DO=5; DSO timing measured from the 9th accepted sample.
- All samples 255, then all samples 0 with duplicates -> DO=255 then DO=0, no X. DSI pulses during SORT are ignored; the next window count starts at 0.
- Back-to-back: second window (10..90 step 10, shuffled) begins in the DSO cycle -> second DO=50. First DO held until the second DSO.
- nRST low for 1 cycle at SORT pass 4 -> DO=0, DSO=0, BUSY=0, no DSO. With RANK_FILTER_EARLY_EXIT_EN, sorted input 1..9 gives DO=5 in the cycle after edge k+2.

Source files
------------

// File: rtl/rank_filter_pkg.sv
// ============================================================================
// Module      : rank_filter_pkg
// Description : Shared types, constants and parameter checks for rank_filter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rank_filter_pkg;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        SORT = 1'b1
    } state_e;

    localparam int RANK_MIN = 0;

    function automatic int median_rank(input int p);
        return (p - 1) / 2;
    endfunction

    // Window depth must be odd so the median rank is a single element.
    function automatic bit depth_is_legal(input int p);
        return ((p % 2) == 1) && (p >= 3) && (p <= 25);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rank_filter_oe_pass.sv
// ============================================================================
// Module      : rank_filter_oe_pass
// Description : One combinational odd-even transposition pass over P samples.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rank_filter_oe_pass
    import rank_filter_pkg::*;
#(
    parameter int W = 8,
    parameter int P = 9
) (
    input  logic [P*W-1:0] i_arr,
    input  logic           i_odd,
    output logic [P*W-1:0] o_arr,
    output logic           o_any_swap
);

    // w_sw[k] set when the pair (k-1, k) is active this pass and out of order.
    logic [P-1:1] w_sw;

    genvar k;
    for (k = 1; k < P; k++) begin : g_cmp
        localparam bit c_odd = ((k - 1) % 2) == 1;
        assign w_sw[k] = (c_odd == i_odd) &&
                         (i_arr[(k-1)*W +: W] > i_arr[k*W +: W]);
    end

    genvar j;
    for (j = 0; j < P; j++) begin : g_elem
        if (j == 0) begin : g_first
            assign o_arr[j*W +: W] = w_sw[1] ? i_arr[W +: W] : i_arr[0 +: W];
        end else if (j == P - 1) begin : g_last
            assign o_arr[j*W +: W] = w_sw[j] ? i_arr[(j-1)*W +: W] : i_arr[j*W +: W];
        end else begin : g_mid
            assign o_arr[j*W +: W] = w_sw[j+1] ? i_arr[(j+1)*W +: W] :
                                     w_sw[j]   ? i_arr[(j-1)*W +: W] :
                                                 i_arr[j*W +: W];
        end
    end

    assign o_any_swap = |w_sw;

endmodule

`default_nettype wire

// File: rtl/rank_filter.sv
// ============================================================================
// Module      : rank_filter
// Description : Windowed rank filter (min/median/max/any rank) over a sample
//               stream; optional early sort exit via RANK_FILTER_EARLY_EXIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rank_filter
    import rank_filter_pkg::*;
#(
    parameter int W  = 8,
    parameter int P  = 9,
    parameter int RW = $clog2(P)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic [W-1:0]  DI,
    input  logic          DSI,
    input  logic [RW-1:0] RANK,
    output logic [W-1:0]  DO,
    output logic          DSO,
    output logic          BUSY
);

    localparam logic [RW-1:0] c_last  = RW'(P - 1);
    localparam logic [RW-1:0] c_depth = RW'(P);

    if (!depth_is_legal(P)) begin : g_bad_depth
        $error("rank_filter: P must be odd and within 3..25");
    end

    state_e          state_q, state_d;
    logic [RW-1:0]   cnt_q,   cnt_d;
    logic [RW-1:0]   pass_q,  pass_d;
    logic [RW-1:0]   rank_q,  rank_d;
    logic [P*W-1:0]  arr_q,   arr_d;
    logic [W-1:0]    do_q,    do_d;
    logic            dso_q,   dso_d;
    logic            busy_q,  busy_d;

    logic [P*W-1:0]  w_pass_arr;
    logic            w_any_swap;
    logic            w_done;

    rank_filter_oe_pass #(
        .W (W),
        .P (P)
    ) u_pass (
        .i_arr      (arr_q),
        .i_odd      (pass_q[0]),
        .o_arr      (w_pass_arr),
        .o_any_swap (w_any_swap)
    );

`ifdef RANK_FILTER_EARLY_EXIT_EN
    logic swap_prev_q, swap_prev_d;

    // Two consecutive clean passes (one of each parity) prove the array sorted.
    assign w_done = (pass_q == c_last) ||
                    ((pass_q != '0) && !w_any_swap && !swap_prev_q);
`else
    logic unused_any_swap;

    assign unused_any_swap = w_any_swap;
    assign w_done          = (pass_q == c_last);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        rank_d  = rank_q;
        arr_d   = arr_q;
        do_d    = do_q;
        dso_d   = 1'b0;
        busy_d  = busy_q;
`ifdef RANK_FILTER_EARLY_EXIT_EN
        swap_prev_d = swap_prev_q;
`endif
        case (state_q)
            LOAD: begin
                if (DSI) begin
                    arr_d = {arr_q[(P-1)*W-1:0], DI};
                    if (cnt_q == '0) begin
                        rank_d = (RANK >= c_depth) ? c_last : RANK;
                    end
                    if (cnt_q == c_last) begin
                        cnt_d   = '0;
                        pass_d  = '0;
                        state_d = SORT;
                        busy_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SORT: begin
                arr_d  = w_pass_arr;
                pass_d = pass_q + 1'b1;
`ifdef RANK_FILTER_EARLY_EXIT_EN
                swap_prev_d = w_any_swap;
`endif
                if (w_done) begin
                    for (int i = 0; i < P; i++) begin
                        if (rank_q == RW'(i)) begin
                            do_d = w_pass_arr[i*W +: W];
                        end
                    end
                    dso_d   = 1'b1;
                    pass_d  = '0;
                    state_d = LOAD;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            pass_q  <= '0;
            rank_q  <= '0;
            do_q    <= '0;
            dso_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef RANK_FILTER_EARLY_EXIT_EN
            swap_prev_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            rank_q  <= rank_d;
            do_q    <= do_d;
            dso_q   <= dso_d;
            busy_q  <= busy_d;
`ifdef RANK_FILTER_EARLY_EXIT_EN
            swap_prev_q <= swap_prev_d;
`endif
        end
    end

    // Sample storage carries no reset; its contents are meaningless until filled.
    always_ff @(posedge CLK) begin
        arr_q <= arr_d;
    end

    assign DO   = do_q;
    assign DSO  = dso_q;
    assign BUSY = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_rank_filter.sv
// ============================================================================
// Module      : tb_rank_filter
// Description : Self-checking bench for rank_filter (W=8, P=9).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rank_filter;

    localparam int W = 8;
    localparam int P = 9;
`ifdef RANK_FILTER_EARLY_EXIT_EN
    localparam int LAT_MIN = 2;
`else
    localparam int LAT_MIN = P;
`endif

    logic         CLK = 1'b0;
    logic         nRST;
    logic [W-1:0] DI;
    logic         DSI;
    logic [3:0]   RANK;
    logic [W-1:0] DO;
    logic         DSO;
    logic         BUSY;

    int n_cmp = 0;
    int n_bad = 0;

    rank_filter #(.W(W), .P(P)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .DI   (DI),
        .DSI  (DSI),
        .RANK (RANK),
        .DO   (DO),
        .DSO  (DSO),
        .BUSY (BUSY)
    );

    always #5 CLK = ~CLK;

    // Value of rank r: the element with (#smaller <= r < #smaller-or-equal).
    function automatic logic [7:0] ref_rank(input logic [7:0] s [9], input int r);
        int rr;
        int lt;
        int le;
        rr = (r > P - 1) ? P - 1 : r;
        ref_rank = 8'd0;
        for (int i = 0; i < P; i++) begin
            lt = 0;
            le = 0;
            for (int j = 0; j < P; j++) begin
                if (s[j] < s[i])  lt++;
                if (s[j] <= s[i]) le++;
            end
            if (lt <= rr && rr < le) ref_rank = s[i];
        end
    endfunction

    task automatic load_window(input logic [7:0] s [9], input logic [3:0] rank,
                               input int gap_after, input int gap_len);
        for (int i = 0; i < P; i++) begin
            DI  = s[i];
            DSI = 1'b1;
            if (i == 0) RANK = rank;
            @(posedge CLK);
            #1;
            DSI  = 1'b0;
            RANK = 4'($urandom_range(0, 15));
            if (i == gap_after && i < P - 1) begin
                repeat (gap_len) begin
                    @(posedge CLK);
                    #1;
                end
            end
        end
    endtask

    task automatic wait_result(input bit poke, output int lat, output int busy_n,
                               output logic [7:0] dout, output bit do_held);
        logic [7:0] do0;
        do0     = DO;
        lat     = -1;
        busy_n  = (BUSY === 1'b1) ? 1 : 0;
        do_held = 1'b1;
        dout    = DO;
        if (poke) begin
            DSI = 1'b1;
            DI  = 8'($urandom);
        end
        for (int j = 1; j <= 40; j++) begin
            @(posedge CLK);
            #1;
            if (DSO === 1'b1) begin
                lat  = j;
                dout = DO;
                break;
            end
            if (DO !== do0)     do_held = 1'b0;
            if (BUSY === 1'b1)  busy_n++;
            if (poke) DI = 8'($urandom);
        end
        DSI = 1'b0;
    endtask

    task automatic test_reset;
        nRST = 1'b0;
        DSI  = 1'b0;
        DI   = '0;
        RANK = '0;
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++; if (DO !== 8'd0)  begin n_bad++; $display("FAIL reset_do: got %0h expected 0", DO); end
        n_cmp++; if (DSO !== 1'b0) begin n_bad++; $display("FAIL reset_dso: got %0b expected 0", DSO); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b expected 0", BUSY); end
        nRST = 1'b1;
    endtask

    task automatic test_median;
        logic [7:0] win [9];
        int lat, busy_n;
        logic [7:0] dout;
        bit held;
        win = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5, 8'd8, 8'd2, 8'd6, 8'd4};
        load_window(win, 4'd4, -1, 0);
        wait_result(1'b0, lat, busy_n, dout, held);
        n_cmp++; if (dout !== ref_rank(win, 4)) begin n_bad++; $display("FAIL median_do: got %0d expected %0d", dout, ref_rank(win, 4)); end
        n_cmp++; if (lat < LAT_MIN || lat > P) begin n_bad++; $display("FAIL median_latency: got %0d expected %0d..%0d", lat, LAT_MIN, P); end
        n_cmp++; if (busy_n != lat) begin n_bad++; $display("FAIL median_busy_cycles: got %0d expected %0d", busy_n, lat); end
        @(posedge CLK);
        #1;
        n_cmp++; if (DSO !== 1'b0) begin n_bad++; $display("FAIL median_dso_width: got %0b expected 0", DSO); end
        n_cmp++; if (DO !== 8'd5) begin n_bad++; $display("FAIL median_do_hold: got %0d expected 5", DO); end
    endtask

    task automatic test_rank_select;
        logic [7:0] win [9];
        logic [3:0] ranks [3];
        int lat, busy_n;
        logic [7:0] dout;
        bit held;
        win   = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5, 8'd8, 8'd2, 8'd6, 8'd4};
        ranks = '{4'd0, 4'd8, 4'd12};
        for (int r = 0; r < 3; r++) begin
            load_window(win, ranks[r], -1, 0);
            wait_result(1'b0, lat, busy_n, dout, held);
            n_cmp++; if (dout !== ref_rank(win, int'(ranks[r]))) begin n_bad++; $display("FAIL rank_sel_%0d: got %0d expected %0d", ranks[r], dout, ref_rank(win, int'(ranks[r]))); end
        end
    endtask

    task automatic test_gaps;
        logic [7:0] win [9];
        int lat, busy_n;
        logic [7:0] dout;
        bit held;
        win = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5, 8'd8, 8'd2, 8'd6, 8'd4};
        load_window(win, 4'd4, 3, 3);
        wait_result(1'b0, lat, busy_n, dout, held);
        n_cmp++; if (dout !== 8'd5) begin n_bad++; $display("FAIL gap_do: got %0d expected 5", dout); end
        n_cmp++; if (lat < LAT_MIN || lat > P) begin n_bad++; $display("FAIL gap_latency: got %0d expected %0d..%0d", lat, LAT_MIN, P); end
    endtask

    task automatic test_extremes;
        logic [7:0] win [9];
        int lat, busy_n;
        logic [7:0] dout;
        bit held;
        for (int i = 0; i < P; i++) win[i] = 8'd255;
        load_window(win, 4'd4, -1, 0);
        wait_result(1'b1, lat, busy_n, dout, held);
        n_cmp++; if (dout !== 8'd255) begin n_bad++; $display("FAIL all_255_do: got %0h expected ff", dout); end
        for (int i = 0; i < P; i++) win[i] = 8'd0;
        load_window(win, 4'd4, -1, 0);
        wait_result(1'b1, lat, busy_n, dout, held);
        n_cmp++; if (dout !== 8'd0) begin n_bad++; $display("FAIL all_0_do: got %0h expected 0", dout); end
        win = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5, 8'd8, 8'd2, 8'd6, 8'd4};
        load_window(win, 4'd4, -1, 0);
        wait_result(1'b0, lat, busy_n, dout, held);
        n_cmp++; if (dout !== 8'd5) begin n_bad++; $display("FAIL after_poke_do: got %0d expected 5", dout); end
        n_cmp++; if (lat < LAT_MIN || lat > P) begin n_bad++; $display("FAIL after_poke_latency: got %0d expected %0d..%0d", lat, LAT_MIN, P); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] win_a [9];
        logic [7:0] win_b [9];
        int lat, busy_n;
        logic [7:0] dout;
        bit held;
        win_a = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5, 8'd8, 8'd2, 8'd6, 8'd4};
        win_b = '{8'd30, 8'd90, 8'd10, 8'd70, 8'd50, 8'd20, 8'd80, 8'd40, 8'd60};
        load_window(win_a, 4'd4, -1, 0);
        wait_result(1'b0, lat, busy_n, dout, held);
        n_cmp++; if (dout !== 8'd5) begin n_bad++; $display("FAIL b2b_first_do: got %0d expected 5", dout); end
        load_window(win_b, 4'd4, -1, 0);
        n_cmp++; if (DO !== 8'd5) begin n_bad++; $display("FAIL b2b_do_after_load: got %0d expected 5", DO); end
        wait_result(1'b0, lat, busy_n, dout, held);
        n_cmp++; if (!held) begin n_bad++; $display("FAIL b2b_do_held: got changed expected held"); end
        n_cmp++; if (dout !== ref_rank(win_b, 4)) begin n_bad++; $display("FAIL b2b_second_do: got %0d expected %0d", dout, ref_rank(win_b, 4)); end
        n_cmp++; if (lat < LAT_MIN || lat > P) begin n_bad++; $display("FAIL b2b_latency: got %0d expected %0d..%0d", lat, LAT_MIN, P); end
    endtask

    task automatic test_reset_mid_sort;
        logic [7:0] win [9];
        int lat, busy_n;
        logic [7:0] dout;
        bit held;
        bit seen;
        win = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5, 8'd8, 8'd2, 8'd6, 8'd4};
        load_window(win, 4'd8, -1, 0);
        repeat (4) begin
            @(posedge CLK);
            #1;
        end
        nRST = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        n_cmp++; if (DO !== 8'd0)   begin n_bad++; $display("FAIL midsort_reset_do: got %0d expected 0", DO); end
        n_cmp++; if (DSO !== 1'b0)  begin n_bad++; $display("FAIL midsort_reset_dso: got %0b expected 0", DSO); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL midsort_reset_busy: got %0b expected 0", BUSY); end
        seen = 1'b0;
        repeat (15) begin
            @(posedge CLK);
            #1;
            if (DSO !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen) begin n_bad++; $display("FAIL midsort_no_dso: got strobe expected none"); end
        load_window(win, 4'd4, -1, 0);
        wait_result(1'b0, lat, busy_n, dout, held);
        n_cmp++; if (dout !== 8'd5) begin n_bad++; $display("FAIL midsort_recover_do: got %0d expected 5", dout); end
    endtask

    task automatic test_sorted_input;
        logic [7:0] win [9];
        int lat, busy_n;
        logic [7:0] dout;
        bit held;
        for (int i = 0; i < P; i++) win[i] = 8'(i + 1);
        load_window(win, 4'd4, -1, 0);
        wait_result(1'b0, lat, busy_n, dout, held);
        n_cmp++; if (dout !== 8'd5) begin n_bad++; $display("FAIL sorted_do: got %0d expected 5", dout); end
        n_cmp++; if (lat != LAT_MIN) begin n_bad++; $display("FAIL sorted_latency: got %0d expected %0d", lat, LAT_MIN); end
    endtask

    task automatic test_random;
        logic [7:0] win [9];
        logic [3:0] rank;
        int lat, busy_n;
        logic [7:0] dout;
        bit held;
        bit narrow;
        for (int n = 0; n < 25; n++) begin
            narrow = 1'($urandom_range(0, 1));
            for (int i = 0; i < P; i++)
                win[i] = narrow ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
            rank = 4'($urandom_range(0, 15));
            load_window(win, rank, $urandom_range(0, 7), $urandom_range(0, 2));
            wait_result(1'($urandom_range(0, 1)), lat, busy_n, dout, held);
            n_cmp++; if (dout !== ref_rank(win, int'(rank))) begin n_bad++; $display("FAIL random_do[%0d]: got %0d expected %0d", n, dout, ref_rank(win, int'(rank))); end
            n_cmp++; if (lat < LAT_MIN || lat > P) begin n_bad++; $display("FAIL random_latency[%0d]: got %0d expected %0d..%0d", n, lat, LAT_MIN, P); end
        end
    endtask

    initial begin
        test_reset();
        test_median();
        test_rank_select();
        test_gaps();
        test_extremes();
        test_back_to_back();
        test_reset_mid_sort();
        test_sorted_input();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
